// File: rtl/sram_rot90_ctrl.sv
// SRAM image rotator: reads a WxH row-major image and writes it rotated 90 degrees.
// Optional macro ROT_CCW_EN adds a ccw input; a CCW job spends W-1 extra SETUP cycles before the first read.
module sram_rot90_ctrl #(
    parameter int ADDR_SZ   = 20,
    parameter int RAM_WIDTH = 32,
    parameter int DIM_W     = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DIM_W-1:0]     width,
    input  logic [DIM_W-1:0]     height,
    input  logic [ADDR_SZ-1:0]   src_base,
    input  logic [ADDR_SZ-1:0]   dst_base,
`ifdef ROT_CCW_EN
    input  logic                 ccw,
`endif
    output logic                 busy,
    output logic                 done,
    output logic                 sram_en,
    output logic                 sram_we,
    output logic [ADDR_SZ-1:0]   sram_addr,
    output logic [RAM_WIDTH-1:0] sram_wdata,
    input  logic [RAM_WIDTH-1:0] sram_rdata
);

    localparam logic [DIM_W-1:0]   DIM_ONE = DIM_W'(1);
    localparam logic [ADDR_SZ-1:0] A_ONE   = ADDR_SZ'(1);

`ifdef ROT_CCW_EN
    localparam logic [DIM_W-1:0] DIM_TWO = DIM_W'(2);
    typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, SETUP} state_t;
`else
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
`endif

    state_t state, state_n;

    logic [DIM_W-1:0]   w_q, h_q, r, c;
    logic [ADDR_SZ-1:0] src_ptr, dst_ptr, row_dst;
    logic [ADDR_SZ-1:0] h_ext;
    logic               last_col, last_pix, zero_dim;
`ifdef ROT_CCW_EN
    logic               ccw_q;
    logic [DIM_W-1:0]   setup_cnt;
`endif

    assign h_ext    = ADDR_SZ'(h_q);
    assign last_col = (c == w_q - DIM_ONE);
    assign last_pix = last_col && (r == h_q - DIM_ONE);
    assign zero_dim = (width == '0) || (height == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (zero_dim) state_n = DONE;
`ifdef ROT_CCW_EN
                    else if (ccw && width > DIM_ONE) state_n = SETUP;
`endif
                    else state_n = READ;
                end
            end
`ifdef ROT_CCW_EN
            SETUP: if (setup_cnt == w_q - DIM_TWO) state_n = READ;
`endif
            READ:  state_n = WRITE;
            WRITE: state_n = last_pix ? DONE : READ;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Pointers walk incrementally; no multipliers anywhere in the address path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q       <= '0;
            h_q       <= '0;
            r         <= '0;
            c         <= '0;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            row_dst   <= '0;
`ifdef ROT_CCW_EN
            ccw_q     <= 1'b0;
            setup_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        w_q     <= width;
                        h_q     <= height;
                        r       <= '0;
                        c       <= '0;
                        src_ptr <= src_base;
`ifdef ROT_CCW_EN
                        ccw_q     <= ccw;
                        setup_cnt <= '0;
                        if (ccw) begin
                            // First destination is dst_base+(W-1)*H, built up in SETUP.
                            row_dst <= dst_base;
                            dst_ptr <= dst_base;
                        end else begin
                            row_dst <= dst_base + ADDR_SZ'(height) - A_ONE;
                            dst_ptr <= dst_base + ADDR_SZ'(height) - A_ONE;
                        end
`else
                        row_dst <= dst_base + ADDR_SZ'(height) - A_ONE;
                        dst_ptr <= dst_base + ADDR_SZ'(height) - A_ONE;
`endif
                    end
                end
`ifdef ROT_CCW_EN
                SETUP: begin
                    row_dst   <= row_dst + h_ext;
                    dst_ptr   <= dst_ptr + h_ext;
                    setup_cnt <= setup_cnt + DIM_ONE;
                end
`endif
                WRITE: begin
                    src_ptr <= src_ptr + A_ONE;
                    if (last_col) begin
                        c <= '0;
                        r <= r + DIM_ONE;
`ifdef ROT_CCW_EN
                        if (ccw_q) begin
                            row_dst <= row_dst + A_ONE;
                            dst_ptr <= row_dst + A_ONE;
                        end else begin
                            row_dst <= row_dst - A_ONE;
                            dst_ptr <= row_dst - A_ONE;
                        end
`else
                        row_dst <= row_dst - A_ONE;
                        dst_ptr <= row_dst - A_ONE;
`endif
                    end else begin
                        c <= c + DIM_ONE;
`ifdef ROT_CCW_EN
                        dst_ptr <= ccw_q ? dst_ptr - h_ext : dst_ptr + h_ext;
`else
                        dst_ptr <= dst_ptr + h_ext;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // SRAM side is a pure decode of the registered state and pointers.
    always_comb begin
        busy       = (state != IDLE);
        done       = (state == DONE);
        sram_en    = (state == READ) || (state == WRITE);
        sram_we    = (state == WRITE);
        sram_addr  = '0;
        sram_wdata = '0;
        if (state == READ)  sram_addr = src_ptr;
        if (state == WRITE) begin
            sram_addr  = dst_ptr;
            sram_wdata = sram_rdata;
        end
    end

endmodule

// File: tb/tb_sram_rot90_ctrl.sv
// Scoreboard bench for sram_rot90_ctrl: expected SRAM reads/writes are queued by
// the stimulus and consumed by a negedge monitor watching the SRAM port.
module tb_sram_rot90_ctrl;
    localparam int AW = 20;
    localparam int DW = 32;
    localparam int DMW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DMW-1:0] width, height;
    logic [AW-1:0] src_base, dst_base;
`ifdef ROT_CCW_EN
    logic          ccw;
`endif
    logic          busy, done, sram_en, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_rdata;

    sram_rot90_ctrl #(.ADDR_SZ(AW), .RAM_WIDTH(DW), .DIM_W(DMW)) dut (
        .clk(clk), .rst(rst), .start(start), .width(width), .height(height),
        .src_base(src_base), .dst_base(dst_base),
`ifdef ROT_CCW_EN
        .ccw(ccw),
`endif
        .busy(busy), .done(done), .sram_en(sram_en), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    // Source image storage; writes are checked by the scoreboard rather than stored.
    logic [DW-1:0] src_mem [0:(1<<AW)-1];
    always @(posedge clk)
        if (sram_en && !sram_we) sram_rdata <= src_mem[sram_addr];

    logic [AW+DW-1:0] wq[$];
    logic [AW-1:0]    rq[$];
    int checks = 0, failures = 0, done_cnt = 0, en_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (sram_en) en_cnt++;
            if (sram_en && sram_we) begin
                if (wq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_write addr=%0h data=%0h", sram_addr, sram_wdata);
                end else begin
                    chk("wr_addr", 64'(sram_addr), 64'(wq[0][AW+DW-1:DW]));
                    chk("wr_data", 64'(sram_wdata), 64'(wq[0][DW-1:0]));
                    void'(wq.pop_front());
                end
            end
            if (sram_en && !sram_we) begin
                if (rq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_read addr=%0h", sram_addr);
                end else begin
                    chk("rd_addr", 64'(sram_addr), 64'(rq[0]));
                    void'(rq.pop_front());
                end
            end
            if (done) begin
                done_cnt++;
                chk("busy_at_done", 64'(busy), 64'd1);
            end
        end
    end

    task automatic push_w(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wq.push_back({a, d});
    endtask

    task automatic start_job(input int w, input int h, input logic [AW-1:0] sb,
                             input logic [AW-1:0] db, input bit cc);
        width = DMW'(w); height = DMW'(h); src_base = sb; dst_base = db;
`ifdef ROT_CCW_EN
        ccw = cc;
`else
        if (cc) $display("note: ccw requested without ROT_CCW_EN");
`endif
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // n = edge count (from the accepting edge) at which done is first sampled high.
    task automatic wait_done(input string name, input int k0, input int n);
        int k = k0;
        int d0 = done_cnt;
        while (!done && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        chk({name, "_latency"}, 64'(k + 1), 64'(n));
        @(posedge clk); #1;
        chk({name, "_done_pulse_len"}, 64'(done), 64'd0);
        chk({name, "_busy_after"}, 64'(busy), 64'd0);
        chk({name, "_done_count"}, 64'(done_cnt - d0), 64'd1);
        chk({name, "_wq_empty"}, 64'(wq.size()), 64'd0);
        chk({name, "_rq_empty"}, 64'(rq.size()), 64'd0);
    endtask

    initial begin
        int e0, d0;
        rst = 1'b1; start = 1'b0; width = '0; height = '0; src_base = '0; dst_base = '0;
`ifdef ROT_CCW_EN
        ccw = 1'b0;
`endif
        for (int i = 0; i < 6; i++) src_mem[i] = DW'(10 + i);
        #12;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_en", 64'(sram_en), 0);
        chk("rst_we", 64'(sram_we), 0);
        chk("rst_addr", 64'(sram_addr), 0);
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;

        // CW 3x2
        for (int i = 0; i < 6; i++) rq.push_back(AW'(i));
        push_w('h101, 10); push_w('h103, 11); push_w('h105, 12);
        push_w('h100, 13); push_w('h102, 14); push_w('h104, 15);
        start_job(3, 2, 'h0, 'h100, 1'b0);
        chk("cw_busy_on_accept", 64'(busy), 1);
        wait_done("cw3x2", 0, 13);

`ifdef ROT_CCW_EN
        // CCW 3x2, two setup cycles ahead of the first read
        for (int i = 0; i < 6; i++) rq.push_back(AW'(i));
        push_w('h104, 10); push_w('h102, 11); push_w('h100, 12);
        push_w('h105, 13); push_w('h103, 14); push_w('h101, 15);
        start_job(3, 2, 'h0, 'h100, 1'b1);
        wait_done("ccw3x2", 0, 15);
`endif

        // zero width: no SRAM traffic at all
        e0 = en_cnt;
        start_job(0, 5, 'h0, 'h100, 1'b0);
        wait_done("zero", 0, 1);
        chk("zero_no_en", 64'(en_cnt - e0), 0);

        // source address wrap
        src_mem['hFFFFF] = 32'hAA; src_mem[0] = 32'hBB;
        rq.push_back('hFFFFF); rq.push_back('h00000);
        push_w('h10, 32'hAA); push_w('h11, 32'hBB);
        start_job(2, 1, 'hFFFFF, 'h10, 1'b0);
        wait_done("wrap", 0, 5);

        // reset during the 5th WRITE of a 4x4 job
        for (int i = 0; i < 16; i++) src_mem['h400 + i] = DW'('h40 + i);
        for (int i = 0; i < 5; i++) rq.push_back(AW'('h400 + i));
        push_w('h503, 'h40); push_w('h507, 'h41); push_w('h50B, 'h42); push_w('h50F, 'h43);
        start_job(4, 4, 'h400, 'h500, 1'b0);
        repeat (9) begin @(posedge clk); #1; end
        chk("mid_in_write", 64'(sram_we), 1);
        d0 = done_cnt;
        rst = 1'b1; #1;
        chk("mid_rst_en", 64'(sram_en), 0);
        chk("mid_rst_we", 64'(sram_we), 0);
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_addr", 64'(sram_addr), 0);
        @(posedge clk); #1; rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("mid_no_done", 64'(done_cnt - d0), 0);
        chk("mid_wq_empty", 64'(wq.size()), 0);
        chk("mid_rq_empty", 64'(rq.size()), 0);
        src_mem['h600] = 32'h77;
        rq.push_back('h600); push_w('h700, 32'h77);
        start_job(1, 1, 'h600, 'h700, 1'b0);
        wait_done("post_rst_1x1", 0, 3);

        // start while busy is ignored
        for (int i = 0; i < 4; i++) begin
            src_mem['h200 + i] = DW'(20 + i);
            rq.push_back(AW'('h200 + i));
        end
        push_w('h301, 20); push_w('h303, 21); push_w('h300, 22); push_w('h302, 23);
        start_job(2, 2, 'h200, 'h300, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        width = 1; height = 1; src_base = 'h600; dst_base = 'h700; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("busy_start", 3, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sram_rot90_ctrl.md
Name: sram_rot90_ctrl

Overview:
Initiator-side controller for the single-port synchronous SRAM.
- Reads a W×H source image of one-word pixels, row-major, from a source region.
- Writes the image rotated 90° clockwise, row-major H-wide × W-tall, to a destination region of the same SRAM.
- Sits between the top-level sequencer (start/done) and the SRAM port; it is the only SRAM master while busy.

Parameters:
ADDR_SZ, 20, SRAM word address width
RAM_WIDTH, 32, SRAM data / pixel width
DIM_W, 10, width of image dimension inputs (max 2^DIM_W-1 per side)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  begin job; sampled only in IDLE
width  input  DIM_W  source columns W; latched on accepted start
height  input  DIM_W  source rows H; latched on accepted start
src_base  input  ADDR_SZ  source word address of pixel (0,0); latched
dst_base  input  ADDR_SZ  destination word address; latched
busy  output  1  high from cycle after accepted start until DONE exits
done  output  1  one-cycle pulse at job end
sram_en  output  1  SRAM enable
sram_we  output  1  SRAM write enable
sram_addr  output  ADDR_SZ  SRAM address
sram_wdata  output  RAM_WIDTH  SRAM write data
sram_rdata  input  RAM_WIDTH  SRAM read data; valid the cycle after a read cycle, held until next read

Behaviour:
- Reset (async, any time): state=IDLE. busy, done, sram_en, sram_we = 0; sram_addr = 0; all counters = 0. A job in progress is abandoned, no done pulse. The SRAM sees en=0 immediately.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - start=1 latches all job inputs and clears r=c=0.
  - If W==0 or H==0, next state is DONE; otherwise READ.
  - start while not IDLE is ignored.
- READ: sram_en=1, sram_we=0, sram_addr=src_ptr. Next state is WRITE.
- WRITE:
  - sram_en=1, sram_we=1, sram_addr=dst_ptr, sram_wdata=sram_rdata (pass-through of the word read in the preceding READ).
  - If c==W-1 and r==H-1, next state is DONE; otherwise advance and go to READ.
- DONE: done=1 for exactly one cycle, busy=1. Next state is IDLE.
- busy: 1 in READ, WRITE and DONE; 0 in IDLE.
- sram_en/sram_we/sram_addr are decoded from registered state and pointers only; no combinational path from start.
- Addressing (no multipliers; incremental pointers):
  - src_ptr starts at src_base and increments by 1 after each WRITE, i.e. src = src_base + r*W + c.
  - CW destination of (r,c) is (c, H-1-r), so dst = dst_base + c*H + (H-1-r).
  - row_dst is initialised to dst_base+H-1. dst_ptr starts at row_dst.
  - On each column step, dst_ptr += H.
  - At end of row (c==W-1): row_dst -= 1, dst_ptr = row_dst-1, c=0, r+=1.
- All address arithmetic is modulo 2^ADDR_SZ; wrap is silent.
- Throughput: 2 cycles per pixel. done asserts 2*W*H+1 cycles after the edge that accepted start (1 cycle when W or H is 0).
- Source/destination overlap is not checked; behaviour is the literal read/write sequence above.

Optional Feature:
ROT_CCW_EN
- Defined:
  - Adds input port ccw (1 bit), latched on accepted start.
  - ccw=1 rotates counter-clockwise: (r,c) maps to (W-1-c, r), so dst = dst_base + (W-1-c)*H + r.
  - Implementation: row_dst init = dst_base+(W-1)*H, computed incrementally in a setup accumulation or as a per-job precompute. Per column step dst_ptr -= H. At row end row_dst += 1.
  - Any setup cycles add to latency and are documented in the RTL header. Test counts below apply to ccw=0.
- Undefined: no ccw port; CW only.

Test Plan:
- CW 3×2: src_base=0 holds 10,11,12,13,14,15; dst_base=0x100; start -> 0x100..0x105 = 13,10,14,11,15,12; done pulse exactly 13 cycles after start edge; busy low next cycle.
- CCW (ROT_CCW_EN, ccw=1), same image -> 0x100..0x105 = 12,15,11,14,10,13; each source read once, exactly 6 writes.
- Zero size: width=0, height=5, start -> no cycle with sram_en=1; done pulses 1 cycle after start edge.
- Address wrap: src_base=0xFFFFF, W=2, H=1, dst_base=0x10 -> reads at 0xFFFFF then 0x00000; writes to 0x10, 0x11 with the corresponding data.
- Reset mid-job: 4×4 job, assert rst during 5th WRITE -> sram_en/sram_we drop within the reset cycle, no done pulse; a new start afterwards completes a 1×1 copy correctly.
- Start while busy: pulse start with different dims during a 2×2 job -> ignored; output matches the first job; exactly one done pulse.
